// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: hazard FSM states and counter width.
package riscv_pipe_pkg;

    localparam int CNT_W = 32;

    typedef enum logic [1:0] {
        HZ_RUN        = 2'd0,
        HZ_LOAD_STALL = 2'd1,
        HZ_FLUSH      = 2'd2,
        HZ_MEM_WAIT   = 2'd3
    } hz_state_t;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter
    import riscv_pipe_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic         clr_i,
    output logic [W-1:0] value_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, memory freeze.
module hazard_ctrl
    import riscv_pipe_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       IF_ID_rs1,
    input  logic [4:0]       IF_ID_rs2,
    input  logic             IF_ID_use_rs1,
    input  logic             IF_ID_use_rs2,
    input  logic [4:0]       ID_EX_rd,
    input  logic             ID_EX_MemRead,
    input  logic             EX_branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             ID_EX_Write,
    output logic             EX_MEM_Write,
    output logic             MEM_WB_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    hz_state_t state_q, state_d;
    logic      load_use;
    logic      mem_busy;
    logic      freeze;

    assign load_use = ID_EX_MemRead && (ID_EX_rd != 5'd0) &&
                      ((IF_ID_use_rs1 && (ID_EX_rd == IF_ID_rs1)) ||
                       (IF_ID_use_rs2 && (ID_EX_rd == IF_ID_rs2)));

    assign mem_busy = dmem_req && !dmem_ready;
    // An outstanding access keeps the pipe frozen until ready arrives.
    assign freeze   = mem_busy ||
                      ((state_q == HZ_MEM_WAIT) && !dmem_ready);

    always_comb begin
        PCWrite      = 1'b1;
        IF_ID_Write  = 1'b1;
        ID_EX_Write  = 1'b1;
        EX_MEM_Write = 1'b1;
        MEM_WB_Write = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Flush  = 1'b0;
        state_d      = HZ_RUN;
        priority case (1'b1)
            reset: begin
                state_d = HZ_RUN;
            end
            freeze: begin
                PCWrite      = 1'b0;
                IF_ID_Write  = 1'b0;
                ID_EX_Write  = 1'b0;
                EX_MEM_Write = 1'b0;
                MEM_WB_Write = 1'b0;
                state_d      = HZ_MEM_WAIT;
            end
            EX_branch_taken: begin
                IF_ID_Flush = 1'b1;
                ID_EX_Flush = 1'b1;
                state_d     = HZ_FLUSH;
            end
            load_use: begin
                PCWrite     = 1'b0;
                IF_ID_Write = 1'b0;
                ID_EX_Flush = 1'b1;
                state_d     = HZ_LOAD_STALL;
            end
            default: begin
                state_d = HZ_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= HZ_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i   (clk),
        .rst_i   (reset),
        .en_i    (!PCWrite),
        .clr_i   (1'b0),
        .value_o (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i   (clk),
        .rst_i   (reset),
        .en_i    (IF_ID_Flush),
        .clr_i   (1'b0),
        .value_o (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl against a rule-level reference model.
module tb_hazard_ctrl;
    import riscv_pipe_pkg::*;

    typedef struct {
        bit       rst;
        bit [4:0] rs1;
        bit [4:0] rs2;
        bit [4:0] rd;
        bit       u1;
        bit       u2;
        bit       mr;
        bit       br;
        bit       rq;
        bit       rdy;
    } stim_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  IF_ID_rs1 = '0, IF_ID_rs2 = '0, ID_EX_rd = '0;
    logic        IF_ID_use_rs1 = 0, IF_ID_use_rs2 = 0;
    logic        ID_EX_MemRead = 0, EX_branch_taken = 0;
    logic        dmem_req = 0, dmem_ready = 0;
    logic        PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write;
    logic        MEM_WB_Write, IF_ID_Flush, ID_EX_Flush;
    logic [1:0]  state;
    logic [31:0] stall_cnt, flush_cnt;

    int     total = 0;
    int     bad = 0;
    int     m_state = 0;
    longint m_stall = 0;
    longint m_flush = 0;
    bit     pending = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .IF_ID_rs1       (IF_ID_rs1),
        .IF_ID_rs2       (IF_ID_rs2),
        .IF_ID_use_rs1   (IF_ID_use_rs1),
        .IF_ID_use_rs2   (IF_ID_use_rs2),
        .ID_EX_rd        (ID_EX_rd),
        .ID_EX_MemRead   (ID_EX_MemRead),
        .EX_branch_taken (EX_branch_taken),
        .dmem_req        (dmem_req),
        .dmem_ready      (dmem_ready),
        .PCWrite         (PCWrite),
        .IF_ID_Write     (IF_ID_Write),
        .ID_EX_Write     (ID_EX_Write),
        .EX_MEM_Write    (EX_MEM_Write),
        .MEM_WB_Write    (MEM_WB_Write),
        .IF_ID_Flush     (IF_ID_Flush),
        .ID_EX_Flush     (ID_EX_Flush),
        .state           (state),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0};
        return s;
    endfunction

    // Expected controls come straight from the event priority rules;
    // the model then advances its state/counters as the DUT will.
    task automatic model_check();
        logic [6:0] exp_v, act_v;
        bit         busy, lu;
        longint     lim = 64'hFFFF_FFFF;
        act_v = {PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write,
                 MEM_WB_Write, IF_ID_Flush, ID_EX_Flush};
        if (reset) begin
            m_state = 0;
            m_stall = 0;
            m_flush = 0;
        end
        check("m_state", {62'd0, state}, m_state);
        check("m_stall", {32'd0, stall_cnt}, m_stall);
        check("m_flush", {32'd0, flush_cnt}, m_flush);
        busy = dmem_req && !dmem_ready;
        lu = ID_EX_MemRead && (ID_EX_rd != 0) &&
             ((IF_ID_use_rs1 && ID_EX_rd == IF_ID_rs1) ||
              (IF_ID_use_rs2 && ID_EX_rd == IF_ID_rs2));
        if (reset)                exp_v = 7'b1111100;
        else if (busy)            exp_v = 7'b0000000;
        else if (EX_branch_taken) exp_v = 7'b1111111;
        else if (lu)              exp_v = 7'b0011101;
        else                      exp_v = 7'b1111100;
        check("m_ctl", {57'd0, act_v}, {57'd0, exp_v});
        if (!reset) begin
            if (!exp_v[6] && m_stall < lim) m_stall++;
            if (exp_v[1] && m_flush < lim) m_flush++;
            m_state = busy ? 3 : EX_branch_taken ? 2 : lu ? 1 : 0;
        end
    endtask

    task automatic apply(input stim_t s);
        reset           = s.rst;
        IF_ID_rs1       = s.rs1;
        IF_ID_rs2       = s.rs2;
        ID_EX_rd        = s.rd;
        IF_ID_use_rs1   = s.u1;
        IF_ID_use_rs2   = s.u2;
        ID_EX_MemRead   = s.mr;
        EX_branch_taken = s.br;
        dmem_req        = s.rq;
        dmem_ready      = s.rdy;
    endtask

    task automatic cycle(input stim_t s);
        @(posedge clk);
        #1;
        apply(s);
        @(negedge clk);
        model_check();
    endtask

    initial begin
        stim_t s, lu;
        lu = idle();
        lu.mr = 1; lu.rd = 5; lu.rs1 = 5; lu.u1 = 1;

        s = idle(); s.rst = 1; s.br = 1; s.rq = 1;
        cycle(s);
        check("rst_pcw", PCWrite, 1);
        check("rst_flush", IF_ID_Flush, 0);
        check("rst_state", state, 0);
        cycle(idle());
        check("post_rst_stall", stall_cnt, 0);

        cycle(lu);
        check("lu_pcw", PCWrite, 0);
        check("lu_ifidw", IF_ID_Write, 0);
        check("lu_idexf", ID_EX_Flush, 1);
        check("lu_exmemw", EX_MEM_Write, 1);
        cycle(idle());
        check("lu_state", state, 1);
        check("lu_stall", stall_cnt, 1);
        check("lu_release", PCWrite, 1);

        s = idle(); s.mr = 1; s.rd = 0; s.rs1 = 0; s.u1 = 1;
        cycle(s);
        check("x0_pcw", PCWrite, 1);
        cycle(idle());
        check("x0_state", state, 0);
        check("x0_stall", stall_cnt, 1);

        s = lu; s.br = 1;
        cycle(s);
        check("br_ifidf", IF_ID_Flush, 1);
        check("br_idexf", ID_EX_Flush, 1);
        check("br_pcw", PCWrite, 1);
        cycle(idle());
        check("br_state", state, 2);
        check("br_flush", flush_cnt, 1);
        check("br_stall", stall_cnt, 1);

        s = idle(); s.rq = 1;
        for (int i = 0; i < 3; i++) begin
            cycle(s);
            check("mw_frozen", {PCWrite, IF_ID_Write, ID_EX_Write,
                                EX_MEM_Write, MEM_WB_Write}, 0);
        end
        s.rdy = 1;
        cycle(s);
        check("mw_release", {PCWrite, IF_ID_Write, ID_EX_Write,
                             EX_MEM_Write, MEM_WB_Write}, 5'h1f);
        check("mw_state3", state, 3);
        cycle(idle());
        check("mw_state0", state, 0);
        check("mw_stall", stall_cnt, 4);

        s = idle(); s.rq = 1;
        cycle(s);
        cycle(s);
        check("mr_wait", state, 3);
        #2;
        reset = 1'b1;
        #1;
        check("mr_state", state, 0);
        check("mr_stall", stall_cnt, 0);
        check("mr_flush", flush_cnt, 0);
        check("mr_pcw", PCWrite, 1);
        check("mr_memwb", MEM_WB_Write, 1);
        s = idle(); s.rst = 1;
        cycle(s);
        cycle(idle());

        @(posedge clk);
        #1;
        apply(idle());
        force dut.u_stall_cnt.cnt_q = 32'hFFFF_FFFE;
        #2;
        release dut.u_stall_cnt.cnt_q;
        @(negedge clk);
        m_stall = 64'hFFFF_FFFE;
        model_check();
        for (int i = 0; i < 3; i++) cycle(lu);
        cycle(idle());
        check("sat_stall", stall_cnt, 32'hFFFF_FFFF);

        s = idle(); s.rst = 1;
        cycle(s);
        for (int i = 0; i < 500; i++) begin
            s = idle();
            s.rst = ($urandom_range(63) == 0);
            s.rs1 = 5'($urandom_range(3));
            s.rs2 = 5'($urandom_range(3));
            s.rd  = 5'($urandom_range(3));
            s.u1  = 1'($urandom_range(1));
            s.u2  = 1'($urandom_range(1));
            s.mr  = 1'($urandom_range(1));
            s.br  = ($urandom_range(7) == 0);
            if (pending) begin
                s.rq  = 1;
                s.rdy = ($urandom_range(2) == 0);
                pending = !s.rdy;
            end else begin
                s.rq  = ($urandom_range(3) == 0);
                s.rdy = 1'($urandom_range(1));
                pending = s.rq && !s.rdy;
            end
            cycle(s);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
